// File: rtl/ir_imm_decode.sv
// ir_imm_decode: instruction-register / decode stage feeding the 16-bit
// immediate extender. Accepts {instr, pc} over valid/ready, decodes the
// extension opcode (EOp) and whether the immediate is consumed, and presents
// the registered head entry downstream. A one-entry skid buffer keeps
// in_ready a pure flop while still sustaining one transfer per cycle.
//
// Optional feature: define IR_IMM_DECODE_FLUSH_EN to add a 'flush' input
// that empties both entries on the clock edge where it is high.
module ir_imm_decode #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     imm,
  output logic [1:0]      EOp,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [PC_W-1:0] pc_out,
  output logic            imm_used
`ifdef IR_IMM_DECODE_FLUSH_EN
  ,
  input  logic            flush
`endif
);

  // Occupancy states: EMPTY (nothing held), ONE (head only), FULL (head+skid)
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  // MIPS primary opcodes that consume the extended immediate
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // Extender operation encodings
  localparam logic [1:0] EOP_SIGN   = 2'b00;
  localparam logic [1:0] EOP_ZERO   = 2'b01;
  localparam logic [1:0] EOP_UPPER  = 2'b10;
  localparam logic [1:0] EOP_BRANCH = 2'b11;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic            accept;
  logic            pop;
  logic            flush_now;
  logic            head_load_in;
  logic            head_load_skid;
  logic            skid_load;

  logic [1:0]      dec_eop;
  logic            dec_used;

  logic [15:0]     skid_imm;
  logic [1:0]      skid_eop;
  logic [4:0]      skid_rs;
  logic [4:0]      skid_rt;
  logic [4:0]      skid_rd;
  logic [PC_W-1:0] skid_pc;
  logic            skid_used;

`ifdef IR_IMM_DECODE_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  assign out_valid = (state != S_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Decode the incoming word so both head and skid store ready-made fields
  always_comb begin
    dec_eop  = EOP_SIGN;
    dec_used = 1'b0;
    case (in_instr[31:26])
      OP_ADDIU, OP_LW, OP_SW: begin
        dec_eop  = EOP_SIGN;
        dec_used = 1'b1;
      end
      OP_ORI: begin
        dec_eop  = EOP_ZERO;
        dec_used = 1'b1;
      end
      OP_LUI: begin
        dec_eop  = EOP_UPPER;
        dec_used = 1'b1;
      end
      OP_BEQ: begin
        dec_eop  = EOP_BRANCH;
        dec_used = 1'b1;
      end
      default: begin
        dec_eop  = EOP_SIGN;
        dec_used = 1'b0;
      end
    endcase
  end

  // Occupancy transitions; flush overrides any accept or pop
  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY: begin
        if (accept) state_nxt = S_ONE;
      end
      S_ONE: begin
        if (accept && !pop)      state_nxt = S_FULL;
        else if (!accept && pop) state_nxt = S_EMPTY;
      end
      S_FULL: begin
        if (pop) state_nxt = S_ONE;
      end
      default: state_nxt = S_EMPTY;
    endcase
    if (flush_now) state_nxt = S_EMPTY;
  end

  // Which register captures what this cycle; a flush suppresses every write
  always_comb begin
    head_load_in   = 1'b0;
    head_load_skid = 1'b0;
    skid_load      = 1'b0;
    if (!flush_now) begin
      head_load_in   = accept && ((state == S_EMPTY) || ((state == S_ONE) && pop));
      head_load_skid = (state == S_FULL) && pop;
      skid_load      = accept && (state == S_ONE) && !pop;
    end
  end

  // State and registered upstream ready (low exactly while FULL)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != S_FULL);
    end
  end

  // Head entry: drives the outputs, refilled from input or from the skid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm      <= '0;
      EOp      <= EOP_SIGN;
      rs       <= '0;
      rt       <= '0;
      rd       <= '0;
      pc_out   <= '0;
      imm_used <= 1'b0;
    end else if (head_load_in) begin
      imm      <= in_instr[15:0];
      EOp      <= dec_eop;
      rs       <= in_instr[25:21];
      rt       <= in_instr[20:16];
      rd       <= in_instr[15:11];
      pc_out   <= in_pc;
      imm_used <= dec_used;
    end else if (head_load_skid) begin
      imm      <= skid_imm;
      EOp      <= skid_eop;
      rs       <= skid_rs;
      rt       <= skid_rt;
      rd       <= skid_rd;
      pc_out   <= skid_pc;
      imm_used <= skid_used;
    end
  end

  // Skid entry: catches the word accepted while the head is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_imm  <= '0;
      skid_eop  <= EOP_SIGN;
      skid_rs   <= '0;
      skid_rt   <= '0;
      skid_rd   <= '0;
      skid_pc   <= '0;
      skid_used <= 1'b0;
    end else if (skid_load) begin
      skid_imm  <= in_instr[15:0];
      skid_eop  <= dec_eop;
      skid_rs   <= in_instr[25:21];
      skid_rt   <= in_instr[20:16];
      skid_rd   <= in_instr[15:11];
      skid_pc   <= in_pc;
      skid_used <= dec_used;
    end
  end

endmodule

// File: doc/ir_imm_decode.md
Name: ir_imm_decode

Overview:
- Instruction-register / decode stage sitting directly upstream of the 16-bit immediate extender.
- Accepts fetched 32-bit MIPS instructions with their PC over a valid/ready handshake.
- Registers them and decodes the immediate field and the 2-bit extension opcode (EOp) that drive the extender's imm/EOp inputs.
- Contains a one-entry skid buffer, so upstream ready is fully registered and back-pressure costs no bubbles.

Parameters:
- PC_W, 32, width of the PC carried alongside each instruction.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  stage can accept; registered
- in_instr  input  32  instruction word
- in_pc  input  PC_W  PC of instruction
- out_valid  output  1  decoded entry valid
- out_ready  input  1  downstream accepts
- imm  output  16  instr[15:0] of head entry
- EOp  output  2  extension opcode for extender
- rs  output  5  instr[25:21]
- rt  output  5  instr[20:16]
- rd  output  5  instr[15:11]
- pc_out  output  PC_W  PC of head entry
- imm_used  output  1  head instruction consumes extended immediate

Behaviour:
- Reset (async, rst_n=0): out_valid=0, in_ready=1, skid empty, imm=0, EOp=2'b00, rs=rt=rd=0, pc_out=0, imm_used=0. Reset mid-transfer discards both entries; no partial state survives.
- Storage: head register (drives outputs) plus skid register. Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
- Latency: an instruction accepted in cycle N appears on outputs in cycle N+1 (registered decode).
- States:
  - EMPTY (out_valid=0, in_ready=1): on accept -> ONE.
  - ONE (out_valid=1, in_ready=1):
    - accept & pop -> ONE, head replaced.
    - accept only -> FULL, new entry into skid.
    - pop only -> EMPTY.
    - neither -> hold.
  - FULL (out_valid=1, in_ready=0):
    - pop -> ONE, skid moves to head, skid empties.
    - no pop -> hold.
- in_ready is a flop: cleared on the edge entering FULL, set on the edge leaving it. Outputs are stable while out_valid & !out_ready (no change until pop).
- Decode, performed before the head/skid write; skid stores decoded fields:
  - 001001 addiu, 100011 lw, 101011 sw -> EOp=00 (sign), imm_used=1.
  - 001101 ori -> EOp=01 (zero), imm_used=1.
  - 001111 lui -> EOp=10 (upper 16), imm_used=1.
  - 000100 beq -> EOp=11 (sign, <<2 branch offset), imm_used=1.
  - all others, including R-type 000000 -> EOp=00, imm_used=0.
- imm/rs/rt/rd are always the raw fields, regardless of opcode.
- in_valid while in_ready=0 is ignored; upstream must hold the data.
- Simultaneous accept & pop in ONE state is lossless and keeps throughput at 1/cycle.

Optional Feature:
- Macro IR_IMM_DECODE_FLUSH_EN.
- When defined: extra input flush (1 bit). On a clock edge with flush=1, both entries are invalidated (-> EMPTY, out_valid=0, in_ready=1) and any same-cycle input is dropped. Data fields keep their last values. flush has priority over accept and pop.
- When undefined: no flush port, and behaviour is exactly as above.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with out_valid=1 -> out_valid=0, in_ready=1, EOp=00, imm=0 immediately (async); after release, the first accept emerges one cycle later.
- Decode: stream ori $t0,$t1,0x9A49 (0x35289A49), lui 0x3C089A49, beq 0x11099A49, addiu 0x25289A49 with out_ready=1 -> EOp 01,10,11,00, imm=0x9A49 each, imm_used=1, one per cycle.
- R-type: 0x01095020 -> EOp=00, imm_used=0, rs=8, rt=9, rd=10.
- Back-pressure: out_ready=0, push A then B -> in_ready drops after B, outputs hold A; C is offered and ignored. Raise out_ready -> A, then B, then C accepted; order A,B,C with no loss or duplication.
- Simultaneous: in ONE state with in_valid=1 and out_ready=1 every cycle for 8 cycles -> 8 instructions out in consecutive cycles, in_ready stays 1.
- Flush (macro on): FULL state, pulse flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never appears.
